// File: rtl/fifo_rd_rr_scheduler.sv
// fifo_rd_rr_scheduler: drains NumFifos async FIFOs round-robin, in bursts of up to MaxBurst words, into one valid/ready stream.
// Define FIFO_SCHED_STRICT_PRIO_EN to give FIFO 0 strict, preempting priority over the round-robin set.
module fifo_rd_rr_scheduler #(
   parameter int NumFifos = 4,
   parameter int DataWidth = 32,
   parameter int MaxBurst = 4,
   localparam int IdxWidth = (NumFifos > 1) ? $clog2(NumFifos) : 1,
   localparam int CntWidth = $clog2(MaxBurst + 1)
) (
   input  logic                          rd_clk,
   input  logic                          rd_rst,
   input  logic [NumFifos-1:0]           fifo_empty,
   input  logic [NumFifos*DataWidth-1:0] fifo_data,
   output logic [NumFifos-1:0]           fifo_rd_req,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DataWidth-1:0]          out_data,
   output logic [IdxWidth-1:0]           out_src,
   output logic                          busy
);
   typedef enum logic {IDLE, BURST} state_e;
   state_e state_q, state_d;
   logic [IdxWidth-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, out_src_q, out_src_d, rr_sel, sel;
   logic [CntWidth-1:0] burst_cnt_q, burst_cnt_d;
   logic [DataWidth-1:0] out_data_q, out_data_d;
   logic out_valid_q, out_valid_d, pop, last, preempt, rr_hold;

   function automatic int wrap(input int v);
      return (v >= NumFifos) ? v - NumFifos : v;
   endfunction

   // Lowest offset from rr_ptr wins, so scan offsets from the far end down.
   always_comb begin
      rr_sel = rr_ptr_q;
      for (int k = NumFifos - 1; k >= 0; k--)
         if (!fifo_empty[wrap(int'(rr_ptr_q) + k)]) rr_sel = IdxWidth'(wrap(int'(rr_ptr_q) + k));
   end

`ifdef FIFO_SCHED_STRICT_PRIO_EN
   assign sel     = !fifo_empty[0] ? '0 : rr_sel;
   assign preempt = (grant_q != '0) && !fifo_empty[0];
   assign rr_hold = grant_q == '0;
`else
   assign sel     = rr_sel;
   assign preempt = 1'b0;
   assign rr_hold = 1'b0;
`endif

   assign pop  = (state_q == BURST) && !fifo_empty[grant_q] && (!out_valid_q || out_ready);
   assign last = burst_cnt_q == CntWidth'(MaxBurst - 1);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      fifo_rd_req = '0;
      fifo_rd_req[grant_q] = pop && !rd_rst;
      if (state_q == IDLE) begin
         if (!(&fifo_empty)) begin
            grant_d     = sel;
            burst_cnt_d = '0;
            state_d     = BURST;
         end
      end else begin
         if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo_data[int'(grant_q)*DataWidth +: DataWidth];
            out_src_d   = grant_q;
            burst_cnt_d = burst_cnt_q + 1'b1;
         end
         if ((pop && last) || fifo_empty[grant_q] || preempt) begin
            state_d  = IDLE;
            rr_ptr_d = rr_hold ? rr_ptr_q : (grant_q == IdxWidth'(NumFifos - 1)) ? '0 : grant_q + 1'b1;
         end
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign busy      = state_q == BURST;
endmodule

// File: tb/tb_fifo_rd_rr_scheduler.sv
// tb_fifo_rd_rr_scheduler: directed bench with a word-level scheduling model and per-cycle protocol checks.
module tb_fifo_rd_rr_scheduler;
   localparam int NF = 4, DW = 32, MB = 4, IW = 2;
   typedef struct packed {logic [IW-1:0] src; logic [DW-1:0] data;} ent_t;

   logic rd_clk = 1'b0, rd_rst = 1'b1, out_ready = 1'b1;
   logic [NF-1:0] fifo_empty, fifo_rd_req;
   logic [NF*DW-1:0] fifo_data;
   logic out_valid, busy;
   logic [DW-1:0] out_data;
   logic [IW-1:0] out_src;

   int n_tests = 0, n_fail = 0, cyc = 0, m_ptr = 0;
   logic [DW-1:0] mem [NF][64];
   logic [5:0] wr [NF] = '{default: 6'd0};
   logic [5:0] rd [NF] = '{default: 6'd0};
   ent_t exp_q[$];
   logic [IW-1:0] acc_src[$];
   int acc_cyc[$];
   logic hold = 1'b0;
   logic [IW-1:0] h_src;
   logic [DW-1:0] h_data;

   fifo_rd_rr_scheduler #(.NumFifos(NF), .DataWidth(DW), .MaxBurst(MB)) dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd_req(fifo_rd_req), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_src(out_src), .busy(busy)
   );

   always #5 rd_clk = ~rd_clk;

   // Source FIFOs: empty flag follows the read pointer, so it is exact the cycle after a pop.
   always @(posedge rd_clk)
      for (int i = 0; i < NF; i++) if (fifo_rd_req[i]) rd[i] <= rd[i] + 6'd1;

   always_comb begin
      fifo_empty = '0;
      fifo_data  = '0;
      for (int i = 0; i < NF; i++) begin
         fifo_empty[i] = rd[i] == wr[i];
         fifo_data[i*DW +: DW] = mem[i][rd[i]];
      end
   end

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [DW-1:0] word(input int tag, input int i, input int k);
      return {8'(tag), 8'(i), 16'(k)};
   endfunction

   task automatic push(input int i, input logic [DW-1:0] v);
      mem[i][wr[i]] = v;
      wr[i] = wr[i] + 6'd1;
   endtask

   task automatic tick();
      @(posedge rd_clk);
      #2;
   endtask

   task automatic clear_log();
      acc_src.delete();
      acc_cyc.delete();
   endtask

   // Fill FIFOs and predict the delivered word order grant by grant.
   task automatic load(input int tag, input int c0, input int c1, input int c2, input int c3);
      int cnt[NF];
      int rem[NF];
      int g, n, left;
      cnt = '{c0, c1, c2, c3};
      rem = cnt;
      left = c0 + c1 + c2 + c3;
      for (int i = 0; i < NF; i++)
         for (int k = 0; k < cnt[i]; k++) push(i, word(tag, i, k));
      while (left > 0) begin
         g = -1;
`ifdef FIFO_SCHED_STRICT_PRIO_EN
         if (rem[0] > 0) g = 0;
`endif
         for (int k = 0; k < NF && g < 0; k++)
            if (rem[(m_ptr + k) % NF] > 0) g = (m_ptr + k) % NF;
         n = (rem[g] < MB) ? rem[g] : MB;
         for (int j = 0; j < n; j++)
            exp_q.push_back('{src: IW'(g), data: word(tag, g, cnt[g] - rem[g] + j)});
         rem[g] -= n;
         left -= n;
`ifdef FIFO_SCHED_STRICT_PRIO_EN
         if (g != 0)
`endif
         m_ptr = (g + 1) % NF;
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 400) begin
         tick();
         t++;
      end
      check("drain_words_left", 64'(exp_q.size()), 64'(0));
      repeat (3) tick();
   endtask

   initial forever begin
      ent_t e;
      @(negedge rd_clk);
      cyc++;
      check("rd_req_onehot0", 64'($onehot0(fifo_rd_req)), 64'(1));
      check("rd_req_to_empty", 64'(fifo_rd_req & fifo_empty), 64'(0));
      if (rd_rst) begin
         check("reset_rd_req", 64'(fifo_rd_req), 64'(0));
         check("reset_state", 64'({out_valid, busy}), 64'(0));
      end else begin
         if (out_valid && !out_ready) check("stall_rd_req", 64'(fifo_rd_req), 64'(0));
         if (|fifo_rd_req) check("busy_on_pop", 64'(busy), 64'(1));
         if (hold) check("stall_hold", 64'({out_valid, out_src, out_data}), 64'({1'b1, h_src, h_data}));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_word", 64'({1'b1, out_src, out_data}), 64'(0));
            else begin
               e = exp_q.pop_front();
               check("word", 64'({out_src, out_data}), 64'({e.src, e.data}));
            end
            acc_src.push_back(out_src);
            acc_cyc.push_back(cyc);
         end
      end
      hold   = !rd_rst && out_valid && !out_ready;
      h_src  = out_src;
      h_data = out_data;
   end

   initial begin
      logic [DW-1:0] cd;
      logic [IW-1:0] cs;
      int bad;
      load(1, 8, 8, 8, 8);
      tick();
      tick();
      rd_rst = 1'b0;
      @(negedge rd_clk);
      check("t1_idle_rd_req", 64'({fifo_rd_req, busy, out_valid}), 64'(0));
      @(negedge rd_clk);
      check("t1_first_pop", 64'({fifo_rd_req, busy}), 64'({4'b0001, 1'b1}));
      drain();
      check("t2_count", 64'(acc_src.size()), 64'(32));
      check("t2_span", 64'(acc_cyc.size() == 32 ? acc_cyc[31] - acc_cyc[0] : -1), 64'(38));
`ifndef FIFO_SCHED_STRICT_PRIO_EN
      bad = 0;
      for (int k = 0; k < acc_src.size(); k++) if (acc_src[k] != IW'((k / 4) % NF)) bad++;
      check("t2_src_pattern", 64'(bad), 64'(0));
`endif
      clear_log();
      load(3, 4, 4, 4, 4);
      tick();
      tick();
      tick();
      out_ready = 1'b0;
      @(negedge rd_clk);
      check("t3_stall_valid", 64'(out_valid), 64'(1));
      cd = out_data;
      cs = out_src;
      repeat (4) tick();
      @(negedge rd_clk);
      check("t3_stall_end", 64'({out_valid, out_src, out_data, fifo_rd_req}), 64'({1'b1, cs, cd, 4'b0000}));
      tick();
      out_ready = 1'b1;
      drain();
      check("t3_count", 64'(acc_src.size()), 64'(16));
      clear_log();
      load(40, 1, 0, 0, 0);
      drain();
      clear_log();
      load(4, 4, 2, 4, 4);
      drain();
      check("t4_count", 64'(acc_src.size()), 64'(14));
`ifndef FIFO_SCHED_STRICT_PRIO_EN
      check("t4_head", 64'(acc_src.size() >= 3 ? {acc_src[0], acc_src[1], acc_src[2]} : 6'h3f), 64'({2'd1, 2'd1, 2'd2}));
`endif
      clear_log();
      load(50, 0, 0, 1, 0);
      drain();
      clear_log();
      load(5, 2, 0, 0, 2);
      drain();
`ifndef FIFO_SCHED_STRICT_PRIO_EN
      check("t5_wrap_order", 64'(acc_src.size() == 4 ? {acc_src[0], acc_src[1], acc_src[2], acc_src[3]} : 8'hff),
            64'({2'd3, 2'd3, 2'd0, 2'd0}));
`endif
      clear_log();
      load(51, 1, 1, 1, 1);
      drain();
`ifndef FIFO_SCHED_STRICT_PRIO_EN
      check("t5_ptr_after_wrap", 64'(acc_src.size() == 4 ? acc_src[0] : 2'd0), 64'(1));
`endif
`ifdef FIFO_SCHED_STRICT_PRIO_EN
      clear_log();
      exp_q.push_back('{src: 2'd2, data: word(6, 2, 0)});
      exp_q.push_back('{src: 2'd0, data: word(6, 0, 0)});
      exp_q.push_back('{src: 2'd0, data: word(6, 0, 1)});
      exp_q.push_back('{src: 2'd3, data: word(6, 3, 0)});
      exp_q.push_back('{src: 2'd3, data: word(6, 3, 1)});
      for (int k = 1; k < 4; k++) exp_q.push_back('{src: 2'd2, data: word(6, 2, k)});
      for (int k = 0; k < 4; k++) push(2, word(6, 2, k));
      tick();
      for (int k = 0; k < 2; k++) begin
         push(0, word(6, 0, k));
         push(3, word(6, 3, k));
      end
      drain();
      check("t6_prio_order", 64'(acc_src.size() == 8 ? {acc_src[0], acc_src[1], acc_src[3], acc_src[5]} : 8'hff),
            64'({2'd2, 2'd0, 2'd3, 2'd2}));
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
